// File: rtl/bcd_convert_ctrl.sv
// Handshaked 14-bit binary to 4-digit packed BCD converter using shift-and-add-3.
// Out-of-range inputs either saturate to 9999 or wrap to the low four decimal digits.
module bcd_convert_ctrl #(
    parameter bit SATURATE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        InValid,
    output logic        InReady,
    input  logic [13:0] Binary,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [15:0] BCD,
    output logic        Overflow,
    output logic        Busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q, state_d;
    logic [13:0] sreg_q, sreg_d;
    logic [19:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] bcd_q, bcd_d;
    logic        ovf_q, ovf_d;
    logic        ovf_pend_q, ovf_pend_d;
    logic [19:0] acc_step;

    // One double-dabble step: correct every digit >= 5, then shift in the next binary bit.
    function automatic logic [19:0] dabble_step(input logic [19:0] acc, input logic bit_in);
        logic [19:0] adj;
        for (int i = 0; i < 5; i++) begin
            adj[4*i +: 4] = (acc[4*i +: 4] >= 4'd5) ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
        end
        return {adj[18:0], bit_in};
    endfunction

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        ovf_pend_d = ovf_pend_q;
        acc_step   = dabble_step(acc_q, sreg_q[13]);

        case (state_q)
            IDLE: begin
                if (InValid) begin
                    if (SATURATE && (Binary > 14'd9999)) begin
                        bcd_d   = 16'h9999;
                        ovf_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        sreg_d     = Binary;
                        acc_d      = '0;
                        cnt_d      = '0;
                        ovf_pend_d = (Binary > 14'd9999);
                        state_d    = SHIFT;
                    end
                end
            end
            SHIFT: begin
                acc_d  = acc_step;
                sreg_d = {sreg_q[12:0], 1'b0};
                cnt_d  = cnt_q + 4'd1;
                // The 14th shift completes here, so the result is taken from this step's output.
                if (cnt_q == 4'd13) begin
                    bcd_d   = acc_step[15:0];
                    ovf_d   = ovf_pend_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (OutReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sreg_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            ovf_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            ovf_pend_q <= ovf_pend_d;
        end
    end

    assign InReady  = (state_q == IDLE);
    assign Busy     = (state_q == SHIFT);
    assign OutValid = (state_q == DONE);
    assign BCD      = bcd_q;
    assign Overflow = ovf_q;

endmodule

// File: tb/tb_bcd_convert_ctrl.sv
// Randomized bench for bcd_convert_ctrl: a saturating and a wrapping instance share
// the input stream and are compared against a decimal-arithmetic reference.
module tb_bcd_convert_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        InValid = 1'b0;
    logic        OutReady = 1'b0;
    logic [13:0] Binary = '0;

    logic        rdy_s, vld_s, ovf_s, busy_s;
    logic [15:0] bcd_s;
    logic        rdy_w, vld_w, ovf_w, busy_w;
    logic [15:0] bcd_w;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bcd_convert_ctrl #(.SATURATE(1'b1)) dut_s (
        .clk(clk), .rst(rst), .InValid(InValid), .InReady(rdy_s), .Binary(Binary),
        .OutValid(vld_s), .OutReady(OutReady), .BCD(bcd_s), .Overflow(ovf_s), .Busy(busy_s)
    );

    bcd_convert_ctrl #(.SATURATE(1'b0)) dut_w (
        .clk(clk), .rst(rst), .InValid(InValid), .InReady(rdy_w), .Binary(Binary),
        .OutValid(vld_w), .OutReady(OutReady), .BCD(bcd_w), .Overflow(ovf_w), .Busy(busy_w)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Decimal digits by plain division; out-of-range values saturate or keep the low four digits.
    function automatic logic [15:0] ref_bcd(input int v, input bit sat);
        int t;
        if (sat && v > 9999) return 16'h9999;
        t = v % 10000;
        return 16'(((t / 1000) << 12) | (((t / 100) % 10) << 8) | (((t / 10) % 10) << 4) | (t % 10));
    endfunction

    function automatic int ref_lat(input int v, input bit sat);
        return (sat && v > 9999) ? 0 : 14;
    endfunction

    // Accept edge has just been driven; follow both instances to their results.
    task automatic run(input int v);
        bit          got_s, got_w;
        int          lat_s, lat_w, e;
        logic [15:0] b_s, b_w;
        logic        o_s, o_w;
        @(posedge clk); #1;
        InValid = 1'b0;
        Binary  = 14'($urandom);
        got_s = 1'b0; got_w = 1'b0; lat_s = -1; lat_w = -1;
        b_s = '0; b_w = '0; o_s = 1'b0; o_w = 1'b0;
        for (e = 0; e <= 40 && !(got_s && got_w); e++) begin
            if (e > 0) begin
                @(posedge clk); #1;
            end
            if (e == 1) begin
                check("busy_w", {busy_w, rdy_w}, 2'b10);
                check("busy_s", {busy_s, rdy_s}, (v <= 9999) ? 2'b10 : 2'b01);
            end
            if (!got_s && vld_s) begin
                got_s = 1'b1; lat_s = e; b_s = bcd_s; o_s = ovf_s;
            end
            if (!got_w && vld_w) begin
                got_w = 1'b1; lat_w = e; b_w = bcd_w; o_w = ovf_w;
            end
        end
        check("done_s", got_s, 1);
        check("done_w", got_w, 1);
        if (got_s) begin
            check($sformatf("bcd_s[%0d]", v), b_s, ref_bcd(v, 1'b1));
            check($sformatf("ovf_s[%0d]", v), o_s, v > 9999);
            check($sformatf("lat_s[%0d]", v), lat_s, ref_lat(v, 1'b1));
        end
        if (got_w) begin
            check($sformatf("bcd_w[%0d]", v), b_w, ref_bcd(v, 1'b0));
            check($sformatf("ovf_w[%0d]", v), o_w, v > 9999);
            check($sformatf("lat_w[%0d]", v), lat_w, ref_lat(v, 1'b0));
        end
        @(posedge clk); #1;
    endtask

    task automatic convert(input int v);
        @(negedge clk);
        Binary   = 14'(v);
        InValid  = 1'b1;
        OutReady = 1'b1;
        check("accept_rdy", {rdy_s, rdy_w}, 2'b11);
        run(v);
    endtask

    task automatic stall(input int v);
        int e;
        @(negedge clk);
        Binary   = 14'(v);
        InValid  = 1'b1;
        OutReady = 1'b0;
        @(posedge clk); #1;
        e = 0;
        while (!(vld_s && vld_w) && e < 40) begin
            InValid = 1'($urandom);
            Binary  = 14'($urandom);
            @(posedge clk); #1;
            e++;
        end
        check("stall_reach", {vld_s, vld_w}, 2'b11);
        for (int i = 0; i < 20; i++) begin
            InValid = 1'($urandom);
            Binary  = 14'($urandom);
            @(posedge clk); #1;
            check("stall_vld", {vld_s, vld_w, rdy_s, rdy_w}, 4'b1100);
            check("stall_bcd_s", {ovf_s, bcd_s}, {v > 9999, ref_bcd(v, 1'b1)});
            check("stall_bcd_w", {ovf_w, bcd_w}, {v > 9999, ref_bcd(v, 1'b0)});
        end
        @(negedge clk);
        OutReady = 1'b1;
        InValid  = 1'b1;
        @(posedge clk); #1;
        InValid = 1'b0;
        check("release_idle", {vld_s, vld_w, rdy_s, rdy_w, busy_s, busy_w}, 6'b001100);
        @(posedge clk); #1;
        check("release_noacc", {rdy_s, rdy_w, busy_s, busy_w}, 4'b1100);
    endtask

    task automatic reset_abort();
        int nv;
        @(negedge clk);
        Binary   = 14'd1234;
        InValid  = 1'b1;
        OutReady = 1'b1;
        @(posedge clk); #1;
        InValid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_s", {rdy_s, vld_s, busy_s, ovf_s, bcd_s}, {4'b1000, 16'h0000});
        check("rst_mid_w", {rdy_w, vld_w, busy_w, ovf_w, bcd_w}, {4'b1000, 16'h0000});
        @(negedge clk);
        rst = 1'b0;
        nv = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (vld_s || vld_w) nv++;
        end
        check("abort_novalid", nv, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2 rst = 1'b1;
        #1;
        check("rst_s", {rdy_s, vld_s, busy_s, ovf_s, bcd_s}, {4'b1000, 16'h0000});
        check("rst_w", {rdy_w, vld_w, busy_w, ovf_w, bcd_w}, {4'b1000, 16'h0000});
        Binary   = 14'd902;
        InValid  = 1'b1;
        OutReady = 1'b1;
        #1 rst = 1'b0;
        run(902);

        convert(31);
        convert(0);
        convert(9999);
        convert(16383);
        convert(10000);
        convert(1);
        stall(5678);
        stall(12345);
        reset_abort();
        convert(4321);

        for (int v = 0; v < 10000; v += 13) convert(v);
        convert(9998);
        repeat (600) convert(int'($urandom_range(0, 16383)));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
